// File: rtl/p4_router_pkg.sv
// Shared P4 router types for the queue tail-pointer path: table entry layout,
// the read/write words exchanged with the congestion manager, AXI4-Lite response codes.
package p4_router_pkg;

    localparam int QUEUE_TAIL_POINTER_DATALEN = 32;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef struct packed {
        logic [15:0] tail_ptr;
        logic [14:0] current_page_ptr;
        logic        current_page_valid;
    } queue_tail_pointer_read_t;

    typedef struct packed {
        logic [15:0] new_tail_ptr;
        logic [14:0] next_page_ptr;
        logic        malloc_approved;
    } queue_tail_pointer_write_t;

    typedef struct packed {
        logic [15:0] tail_ptr;
        logic [14:0] current_page_ptr;
        logic        current_page_valid;
    } qtp_table_entry_t;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_RD_WAIT,
        ST_RD_RESP,
        ST_WR_EXEC,
        ST_WR_RESP
    } qtp_state_e;

    // Page pointer/valid only move when the congestion manager got a fresh page.
    function automatic qtp_table_entry_t qtp_apply_write(qtp_table_entry_t cur,
                                                         queue_tail_pointer_write_t req);
        qtp_table_entry_t nxt;
        nxt          = cur;
        nxt.tail_ptr = req.new_tail_ptr;
        if (req.malloc_approved) begin
            nxt.current_page_ptr   = req.next_page_ptr;
            nxt.current_page_valid = 1'b1;
        end
        return nxt;
    endfunction

    function automatic queue_tail_pointer_read_t qtp_to_read(qtp_table_entry_t e);
        queue_tail_pointer_read_t r;
        r.tail_ptr           = e.tail_ptr;
        r.current_page_ptr   = e.current_page_ptr;
        r.current_page_valid = e.current_page_valid;
        return r;
    endfunction

endpackage

// File: rtl/queue_tail_ptr_responder_if.sv
// AXI4-Lite link between the congestion manager (master) and the tail-pointer responder (slave).
interface queue_tail_ptr_responder_if #(
    parameter int AXI_ADDR_WIDTH = 16
);
    import p4_router_pkg::*;

    logic [AXI_ADDR_WIDTH-1:0]             s_awaddr;
    logic                                  s_awvalid;
    logic                                  s_awready;
    logic [QUEUE_TAIL_POINTER_DATALEN-1:0] s_wdata;
    logic [3:0]                            s_wstrb;
    logic                                  s_wvalid;
    logic                                  s_wready;
    logic [1:0]                            s_bresp;
    logic                                  s_bvalid;
    logic                                  s_bready;
    logic [AXI_ADDR_WIDTH-1:0]             s_araddr;
    logic                                  s_arvalid;
    logic                                  s_arready;
    logic [QUEUE_TAIL_POINTER_DATALEN-1:0] s_rdata;
    logic [1:0]                            s_rresp;
    logic                                  s_rvalid;
    logic                                  s_rready;

    modport slave (
        input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        output s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

    modport master (
        output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
               s_araddr, s_arvalid, s_rready,
        input  s_awready, s_wready, s_bresp, s_bvalid,
               s_arready, s_rdata, s_rresp, s_rvalid
    );

endinterface

// File: rtl/qtp_table_ram.sv
// Single-port synchronous tail-pointer table: one access per cycle, 1-cycle read, write-first.
module qtp_table_ram
    import p4_router_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  qtp_table_entry_t wdata,
    output qtp_table_entry_t rdata
);

    qtp_table_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
                rdata     <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/queue_tail_ptr_responder.sv
// AXI4-Lite responder owning the per-queue tail-pointer table; one transaction in flight.
// Optional per-queue read-modify-write lock: define QTP_RMW_LOCK_EN.
module queue_tail_ptr_responder
    import p4_router_pkg::*;
#(
    parameter int NUM_QUEUES     = 128,
    parameter int AXI_ADDR_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    queue_tail_ptr_responder_if.slave   s,
    output logic                        init_done
);

    localparam int              QW     = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1;
    localparam int              IW     = AXI_ADDR_WIDTH - 2;
    localparam logic [IW-1:0]   NQ_IDX = IW'(NUM_QUEUES);
    localparam logic [QW-1:0]   LAST_Q = QW'(NUM_QUEUES - 1);

    qtp_state_e                state, state_nxt;
    logic [QW-1:0]             init_cnt, q_addr;
    logic                      prio_rd, op_err;
    queue_tail_pointer_write_t wr_req;

    logic [IW-1:0] ar_idx, aw_idx;
    logic          ar_in, aw_in, rd_pend, wr_pend, take_rd, take_wr, lock_ok, wr_err;
    logic          ram_en, ram_we;
    logic [QW-1:0] ram_addr;
    qtp_table_entry_t ram_wdata, ram_rdata;

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s.s_araddr[1:0], s.s_awaddr[1:0]};

    assign ar_idx  = s.s_araddr[AXI_ADDR_WIDTH-1:2];
    assign aw_idx  = s.s_awaddr[AXI_ADDR_WIDTH-1:2];
    assign ar_in   = ar_idx < NQ_IDX;
    assign aw_in   = aw_idx < NQ_IDX;
    assign rd_pend = s.s_arvalid;
    assign wr_pend = s.s_awvalid && s.s_wvalid;

    // On contention alternate with the kind served last; reads win after reset.
    assign take_rd = (state == ST_IDLE) && rd_pend && (!wr_pend || prio_rd);
    assign take_wr = (state == ST_IDLE) && wr_pend && (!rd_pend || !prio_rd);
    assign wr_err  = !aw_in || (s.s_wstrb != 4'hF) || !lock_ok;

`ifdef QTP_RMW_LOCK_EN
    logic [NUM_QUEUES-1:0] lock;

    assign lock_ok = lock[aw_idx[QW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lock <= '0;
        else if (take_rd && ar_in)
            lock[ar_idx[QW-1:0]] <= 1'b1;
        else if (state == ST_WR_EXEC && !op_err)
            lock[q_addr] <= 1'b0;
    end
`else
    assign lock_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_INIT;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:    if (init_cnt == LAST_Q) state_nxt = ST_IDLE;
            ST_IDLE:    if (take_rd)            state_nxt = ST_RD_WAIT;
                        else if (take_wr)       state_nxt = ST_WR_EXEC;
            ST_RD_WAIT:                         state_nxt = ST_RD_RESP;
            ST_RD_RESP: if (s.s_rready)         state_nxt = ST_IDLE;
            ST_WR_EXEC:                         state_nxt = ST_WR_RESP;
            ST_WR_RESP: if (s.s_bready)         state_nxt = ST_IDLE;
            default:                            state_nxt = ST_INIT;
        endcase
    end

    // The accept cycle already reads the entry, so WR_EXEC can merge and write back.
    always_comb begin
        s.s_arready = take_rd;
        s.s_awready = take_wr;
        s.s_wready  = take_wr;
        s.s_rvalid  = (state == ST_RD_RESP);
        s.s_bvalid  = (state == ST_WR_RESP);
        init_done   = (state != ST_INIT);
        ram_en      = 1'b0;
        ram_we      = 1'b0;
        ram_addr    = q_addr;
        ram_wdata   = '0;
        case (state)
            ST_INIT: begin
                ram_en   = 1'b1;
                ram_we   = 1'b1;
                ram_addr = init_cnt;
            end
            ST_IDLE: begin
                if (take_rd) begin
                    ram_en   = 1'b1;
                    ram_addr = ar_idx[QW-1:0];
                end else if (take_wr) begin
                    ram_en   = 1'b1;
                    ram_addr = aw_idx[QW-1:0];
                end
            end
            ST_WR_EXEC: begin
                ram_en    = !op_err;
                ram_we    = !op_err;
                ram_wdata = qtp_apply_write(ram_rdata, wr_req);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_cnt  <= '0;
            prio_rd   <= 1'b1;
            q_addr    <= '0;
            op_err    <= 1'b0;
            wr_req    <= '0;
            s.s_rdata <= '0;
            s.s_rresp <= AXIL_RESP_OKAY;
            s.s_bresp <= AXIL_RESP_OKAY;
        end else begin
            if (state == ST_INIT) init_cnt <= init_cnt + 1'b1;
            if (take_rd) begin
                q_addr  <= ar_idx[QW-1:0];
                op_err  <= !ar_in;
                prio_rd <= 1'b0;
            end else if (take_wr) begin
                q_addr  <= aw_idx[QW-1:0];
                op_err  <= wr_err;
                wr_req  <= queue_tail_pointer_write_t'(s.s_wdata);
                prio_rd <= 1'b1;
            end
            if (state == ST_RD_WAIT) begin
                s.s_rdata <= op_err ? '0 : qtp_to_read(ram_rdata);
                s.s_rresp <= op_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
            end
            if (state == ST_WR_EXEC)
                s.s_bresp <= op_err ? AXIL_RESP_SLVERR : AXIL_RESP_OKAY;
        end
    end

    qtp_table_ram #(.DEPTH(NUM_QUEUES), .AW(QW)) u_table (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_queue_tail_ptr_responder.sv
// Directed + randomized bench for queue_tail_ptr_responder against a queue-array reference model.
module tb_queue_tail_ptr_responder;
    import p4_router_pkg::*;

    localparam int NQ = 128;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init_done;
    int   checks = 0;
    int   errors = 0;

    queue_tail_ptr_responder_if #(.AXI_ADDR_WIDTH(16)) bus ();

    queue_tail_ptr_responder #(.NUM_QUEUES(NQ), .AXI_ADDR_WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s         (bus),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    logic [31:0] mdl   [NQ];
    bit          mlock [NQ];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NQ; i++) begin
            mdl[i]   = 32'h0;
            mlock[i] = 1'b0;
        end
    endtask

    function automatic void model_rd(input logic [15:0] a, output logic [31:0] d, output logic [1:0] r);
        int q = int'(a >> 2);
        if (q >= NQ) begin
            d = 32'h0; r = 2'b10;
        end else begin
            d = mdl[q]; r = 2'b00; mlock[q] = 1'b1;
        end
    endfunction

    function automatic logic [1:0] model_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] strb);
        int q = int'(a >> 2);
        bit bad = (q >= NQ) || (strb != 4'hF);
`ifdef QTP_RMW_LOCK_EN
        if (!bad && !mlock[q]) bad = 1'b1;
`endif
        if (bad) return 2'b10;
        if (d[0]) mdl[q] = d;
        else      mdl[q] = {d[31:16], mdl[q][15:0]};
        mlock[q] = 1'b0;
        return 2'b00;
    endfunction

    task automatic idle_bus();
        bus.s_awaddr = '0; bus.s_awvalid = 0; bus.s_wdata = '0; bus.s_wstrb = '0;
        bus.s_wvalid = 0;  bus.s_bready = 0;  bus.s_araddr = '0; bus.s_arvalid = 0;
        bus.s_rready = 0;
    endtask

    // All bus tasks start and end just after a rising edge.
    task automatic rd_addr(input logic [15:0] a, input string tag);
        bit ok = 0;
        bus.s_arvalid = 1; bus.s_araddr = a;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.s_arready) begin ok = 1; break; end
        end
        chk({tag, "_ar_hs"}, 32'(ok), 32'd1);
        @(posedge clk); #1;
        bus.s_arvalid = 0;
    endtask

    task automatic rd_data(input logic [31:0] exp_d, input logic [1:0] exp_r, input int hold, input string tag);
        bit ok = 0;
        int lat = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk); lat++;
            if (bus.s_rvalid) begin ok = 1; break; end
        end
        chk({tag, "_rvalid"}, 32'(ok), 32'd1);
        if (!ok) return;
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        chk({tag, "_rdata"}, bus.s_rdata, exp_d);
        chk({tag, "_rresp"}, 32'(bus.s_rresp), 32'(exp_r));
        if (hold > 0) begin
            bus.s_arvalid = 1; bus.s_araddr = 16'h0200;
            bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_awaddr = 16'h0200; bus.s_wstrb = 4'h0;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk({tag, "_hold_rvalid"}, 32'(bus.s_rvalid), 32'd1);
            chk({tag, "_hold_rdata"}, bus.s_rdata, exp_d);
            chk({tag, "_hold_arready"}, 32'(bus.s_arready), 32'd0);
            chk({tag, "_hold_awready"}, 32'(bus.s_awready), 32'd0);
        end
        if (hold > 0) begin
            bus.s_arvalid = 0; bus.s_awvalid = 0; bus.s_wvalid = 0;
        end
        bus.s_rready = 1;
        @(posedge clk); #1;
        bus.s_rready = 0;
    endtask

    task automatic wr_bus(input logic [15:0] a, input logic [31:0] d, input logic [3:0] strb,
                          input logic [1:0] exp_r, input string tag);
        bit ok = 0;
        bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_awaddr = a; bus.s_wdata = d; bus.s_wstrb = strb;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.s_awready) begin ok = 1; break; end
        end
        chk({tag, "_aw_hs"}, 32'(ok), 32'd1);
        if (ok) chk({tag, "_wready"}, 32'(bus.s_wready), 32'd1);
        @(posedge clk); #1;
        bus.s_awvalid = 0; bus.s_wvalid = 0;
        if (!ok) return;
        ok = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.s_bvalid) begin ok = 1; break; end
        end
        chk({tag, "_bvalid"}, 32'(ok), 32'd1);
        if (!ok) return;
        chk({tag, "_bresp"}, 32'(bus.s_bresp), 32'(exp_r));
        bus.s_bready = 1;
        @(posedge clk); #1;
        bus.s_bready = 0;
    endtask

    // Literal expectations for directed steps; the model is updated alongside.
    task automatic rd_chk(input logic [15:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r,
                          input int hold, input string tag);
        logic [31:0] md; logic [1:0] mr;
        model_rd(a, md, mr);
        rd_addr(a, tag);
        rd_data(exp_d, exp_r, hold, tag);
    endtask

    task automatic wr_chk(input logic [15:0] a, input logic [31:0] d, input logic [3:0] strb,
                          input logic [1:0] exp_r, input string tag);
        logic [1:0] mr;
        mr = model_wr(a, d, strb);
        wr_bus(a, d, strb, exp_r, tag);
    endtask

    task automatic do_rd(input logic [15:0] a, input int hold);
        logic [31:0] md; logic [1:0] mr;
        model_rd(a, md, mr);
        rd_addr(a, "rnd_rd");
        rd_data(md, mr, hold, "rnd_rd");
    endtask

    task automatic do_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] strb);
        logic [1:0] mr;
        mr = model_wr(a, d, strb);
        wr_bus(a, d, strb, mr, "rnd_wr");
    endtask

    task automatic wait_init(input string tag);
        int  cyc = 0;
        bit  quiet = 1;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); cyc++; #1;
            if (init_done) break;
            if (bus.s_arready || bus.s_awready || bus.s_wready) quiet = 0;
        end
        chk({tag, "_init_cycles"}, 32'(cyc), 32'd128);
        chk({tag, "_no_hs_in_init"}, 32'(quiet), 32'd1);
    endtask

    initial begin
        logic [15:0] a;
        logic [31:0] d;
        logic [3:0]  strb;
        logic [1:0]  mr;
        logic [31:0] md;

        idle_bus();
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        // Requests present during reset and INIT must not be accepted.
        bus.s_arvalid = 1; bus.s_araddr = 16'h001C;
        bus.s_awvalid = 1; bus.s_wvalid = 1; bus.s_awaddr = 16'h001C;
        bus.s_wdata = 32'h00110001; bus.s_wstrb = 4'hF;
        #1;
        chk("rst_arready", 32'(bus.s_arready), 32'd0);
        chk("rst_awready", 32'(bus.s_awready), 32'd0);
        chk("rst_wready",  32'(bus.s_wready),  32'd0);
        chk("rst_rvalid",  32'(bus.s_rvalid),  32'd0);
        chk("rst_bvalid",  32'(bus.s_bvalid),  32'd0);
        chk("rst_rresp",   32'(bus.s_rresp),   32'd0);
        chk("rst_bresp",   32'(bus.s_bresp),   32'd0);
        chk("rst_rdata",   bus.s_rdata,        32'd0);
        chk("rst_init_done", 32'(init_done),   32'd0);

        @(negedge clk); rst_n = 1;
        wait_init("boot");

        // Read and write to queue 7 contend in the first live cycle: read goes first.
        @(negedge clk);
        chk("contend_arready", 32'(bus.s_arready), 32'd1);
        chk("contend_awready", 32'(bus.s_awready), 32'd0);
        @(posedge clk); #1;
        bus.s_arvalid = 0;
        model_rd(16'h001C, md, mr);
        rd_data(32'h0, 2'b00, 0, "contend_rd");
        mr = model_wr(16'h001C, 32'h00110001, 4'hF);
        wr_bus(16'h001C, 32'h00110001, 4'hF, 2'b00, "contend_wr");
        rd_chk(16'h001C, 32'h00110001, 2'b00, 0, "q7_after");

        rd_chk(16'h0014, 32'h00000000, 2'b00, 0, "q5_init");
        wr_chk(16'h0014, 32'h012308AD, 4'hF, 2'b00, "q5_wr1");
        rd_chk(16'h0014, 32'h012308AD, 2'b00, 0, "q5_rd1");
        wr_chk(16'h0014, 32'h02000000, 4'hF, 2'b00, "q5_wr2");
        rd_chk(16'h0014, 32'h020008AD, 2'b00, 10, "q5_stall");
        rd_chk(16'h0200, 32'h00000000, 2'b10, 0, "oob_rd");
        wr_chk(16'h0200, 32'hFFFFFFFF, 4'hF, 2'b10, "oob_wr");
        wr_chk(16'h0014, 32'hDEADBEEF, 4'h7, 2'b10, "q5_strb");
        rd_chk(16'h0017, 32'h020008AD, 2'b00, 0, "q5_unchanged");
`ifdef QTP_RMW_LOCK_EN
        wr_chk(16'h0024, 32'h00AA0001, 4'hF, 2'b10, "q9_unlocked");
        rd_chk(16'h0024, 32'h00000000, 2'b00, 0, "q9_after");
`else
        wr_chk(16'h0024, 32'h00AA0001, 4'hF, 2'b00, "q9_nolock");
        rd_chk(16'h0024, 32'h00AA0001, 2'b00, 0, "q9_after");
`endif

        for (int n = 0; n < 300; n++) begin
            int sel = int'($urandom_range(0, 9));
            if (sel < 8)       a = 16'(($urandom_range(0, 11) << 2) | $urandom_range(0, 3));
            else if (sel == 8) a = 16'(127 << 2);
            else               a = 16'($urandom_range(128, 16383) << 2);
            if ($urandom_range(0, 1) == 0) begin
                do_rd(a, int'($urandom_range(0, 2)));
            end else begin
                d    = $urandom;
                strb = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
                do_wr(a, d, strb);
            end
        end

        // Reset while a read response is outstanding drops it and reclears the table.
        rd_addr(16'h0014, "midrst");
        @(posedge clk); #1;
        chk("midrst_rvalid_before", 32'(bus.s_rvalid), 32'd1);
        rst_n = 0;
        #1;
        chk("midrst_rvalid", 32'(bus.s_rvalid), 32'd0);
        chk("midrst_rdata",  bus.s_rdata,       32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        model_clear();
        @(negedge clk); rst_n = 1;
        wait_init("rerun");
        rd_chk(16'h0014, 32'h00000000, 2'b00, 0, "post_rst_q5");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
